vx_ibuffer_demux: RTL and testbench

// - Per-warp instruction buffer feeding the scoreboard stage of one issue slice.
// - Accepts one decoded instruction per cycle tagged with a warp-in-slice index (wis).
// - Steers it into that warp's FIFO and presents PER_ISSUE_WARPS independent valid/ready streams downstream.
// - Emits per-warp pop pulses to the warp scheduler for credit-based fetch throttling.

---
 rtl/vx_ibuffer_demux.sv | 104 ++++++++++
 tb/tb_vx_ibuffer_demux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vx_ibuffer_demux.sv
// rtl/vx_ibuffer_demux.sv - per-warp instruction buffer with demuxed valid/ready streams
module vx_ibuffer_demux #(
  parameter int PER_ISSUE_WARPS = 4,
  parameter int DATAW           = 64,
  parameter int IBUF_SIZE       = 4,
  parameter int WIS_W           = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1,
  parameter int CNT_W           = $clog2(IBUF_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [WIS_W-1:0]                 in_wis,
  input  logic [DATAW-1:0]                 in_data,
  output logic                             in_ready,
  input  logic [PER_ISSUE_WARPS-1:0]       flush,
  output logic [PER_ISSUE_WARPS-1:0]       out_valid,
  output logic [PER_ISSUE_WARPS*DATAW-1:0] out_data,
  input  logic [PER_ISSUE_WARPS-1:0]       out_ready,
  output logic [PER_ISSUE_WARPS-1:0]       ibuf_pop,
  output logic [PER_ISSUE_WARPS*CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(IBUF_SIZE);

  // Per-warp accept condition; depends only on occupancy and flush.
  logic [PER_ISSUE_WARPS-1:0] warp_rdy;

  // Select the accept condition of the addressed warp; out-of-range wis is never ready.
  always_comb begin
    in_ready = 1'b0;
    for (int w = 0; w < PER_ISSUE_WARPS; w++) begin
      if (in_wis == WIS_W'(w)) in_ready = warp_rdy[w];
    end
  end

  for (genvar w = 0; w < PER_ISSUE_WARPS; w++) begin : g_warp
    logic [DATAW-1:0] mem_q [IBUF_SIZE];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             sel;
    logic             push;
    logic             pop;

    assign sel         = (in_wis == WIS_W'(w));
    assign full        = (count_q == CNT_W'(IBUF_SIZE));
    assign warp_rdy[w] = ~full & ~flush[w];
    assign push        = in_valid & sel & warp_rdy[w];
    assign out_valid[w] = (count_q != '0);
    assign pop         = out_valid[w] & out_ready[w] & ~flush[w];
    assign ibuf_pop[w] = pop;

    // Head is a direct RAM read at rptr; writes only target the slot at wptr,
    // so the head cannot change until it is popped.
    assign out_data[w*DATAW +: DATAW] = mem_q[rptr_q];
    assign count[w*CNT_W +: CNT_W]    = count_q;

    // Next-state for pointers and occupancy; flush drops everything still queued.
    always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush[w]) begin
        rptr_d  = wptr_q;
        count_d = '0;
      end else begin
        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
      end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
      end else begin
        rptr_q  <= rptr_d;
        wptr_q  <= wptr_d;
        count_q <= count_d;
      end
    end

    // Storage RAM write; contents are not reset since count gates visibility.
    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in_data;
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (reset)
      push |-> (count_q < CNT_W'(IBUF_SIZE)));
    a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
      count_q <= CNT_W'(IBUF_SIZE));
    a_pop_valid : assert property (@(posedge clk) disable iff (reset)
      ibuf_pop[w] |-> out_valid[w]);
  end

  a_wis_legal : assert property (@(posedge clk) disable iff (reset)
    in_valid |-> (32'(in_wis) < PER_ISSUE_WARPS));

endmodule

// File: tb/tb_vx_ibuffer_demux.sv
// tb/tb_vx_ibuffer_demux.sv - directed self-checking bench for vx_ibuffer_demux
module tb_vx_ibuffer_demux;

  localparam int NW = 4;
  localparam int DW = 64;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [1:0]        in_wis;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [NW-1:0]     flush;
  logic [NW-1:0]     out_valid;
  logic [NW*DW-1:0]  out_data;
  logic [NW-1:0]     out_ready;
  logic [NW-1:0]     ibuf_pop;
  logic [NW*CW-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  vx_ibuffer_demux #(.PER_ISSUE_WARPS(NW), .DATAW(DW), .IBUF_SIZE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wis(in_wis), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .ibuf_pop(ibuf_pop), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int w);
    return count[w*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] head(input int w);
    return out_data[w*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] wis, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_wis   = wis;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    int pushed;
    int guard;

    reset = 1'b1; in_valid = 1'b0; in_wis = '0; in_data = '0;
    flush = '0; out_ready = '0;
    tick(); tick();
    check("rst_out_valid", {60'd0, out_valid}, 64'h0);
    check("rst_pop", {60'd0, ibuf_pop}, 64'h0);
    check("rst_count", {52'd0, count}, 64'h0);
    reset = 1'b0;
    tick();

    // single push to warp 2, no same-cycle bypass
    in_valid = 1'b1; in_wis = 2'd2; in_data = 64'hA1;
    #1;
    check("nobypass_valid", {60'd0, out_valid}, 64'h0);
    tick();
    in_valid = 1'b0;
    check("w2_valid", {60'd0, out_valid}, 64'h4);
    check("w2_data", head(2), 64'hA1);
    check("w2_count", {61'd0, cnt(2)}, 64'd1);
    out_ready = 4'b0100;
    #1;
    check("w2_pop", {60'd0, ibuf_pop}, 64'h4);
    tick();
    out_ready = '0;
    check("w2_empty", {60'd0, out_valid}, 64'h0);

    // fill warp 0
    for (int i = 0; i < 4; i++) push(2'd0, 64'h10 + 64'(i));
    check("w0_full_cnt", {61'd0, cnt(0)}, 64'd4);
    in_wis = 2'd0; #1;
    check("w0_full_rdy", {63'd0, in_ready}, 64'd0);
    in_wis = 2'd1; #1;
    check("w1_rdy", {63'd0, in_ready}, 64'd1);
    in_wis = 2'd0;
    for (int i = 0; i < 4; i++) begin
      out_ready = 4'b0001;
      #1;
      if (i == 0) check("w0_full_pop_rdy", {63'd0, in_ready}, 64'd0);
      check("w0_drain_data", head(0), 64'h10 + 64'(i));
      check("w0_drain_pop", {60'd0, ibuf_pop}, 64'h1);
      tick();
    end
    check("w0_drained", {63'd0, out_valid[0]}, 64'd0);
    check("w0_empty_nopop", {60'd0, ibuf_pop}, 64'h0);
    out_ready = '0;

    // simultaneous push and pop on warp 1
    push(2'd1, 64'h20);
    in_valid = 1'b1; in_wis = 2'd1; in_data = 64'h21; out_ready = 4'b0010;
    #1;
    check("w1_pp_pop", {60'd0, ibuf_pop}, 64'h2);
    check("w1_pp_head", head(1), 64'h20);
    tick();
    in_valid = 1'b0;
    out_ready = '0;
    check("w1_pp_cnt", {61'd0, cnt(1)}, 64'd1);
    check("w1_pp_new", head(1), 64'h21);
    out_ready = 4'b0010; tick(); out_ready = '0;
    check("w1_empty", {61'd0, cnt(1)}, 64'd0);

    // warp 3 full, then streamed pushes with continuous pop (pointer wrap)
    for (int i = 0; i < 4; i++) begin
      push(2'd3, 64'h30 + 64'(i));
      q.push_back(64'h30 + 64'(i));
    end
    pushed = 0;
    guard = 0;
    out_ready = 4'b1000;
    while ((pushed < 8 || q.size() != 0) && guard < 40) begin
      in_valid = (pushed < 8);
      in_wis   = 2'd3;
      in_data  = 64'h34 + 64'(pushed);
      #1;
      check("w3_rdy", {63'd0, in_ready}, {63'd0, (q.size() < 4)});
      check("w3_valid", {63'd0, out_valid[3]}, {63'd0, (q.size() != 0)});
      if (q.size() != 0) check("w3_order", head(3), q[0]);
      check("w3_cnt_bound", {63'd0, (cnt(3) <= 3'd4)}, 64'd1);
      if (in_valid && q.size() < 4) begin
        q.push_back(in_data);
        pushed++;
      end
      tick();
      void'(q.pop_front());
      guard++;
    end
    in_valid = 1'b0;
    out_ready = '0;
    check("w3_guard", {63'd0, (guard < 40)}, 64'd1);
    check("w3_final_cnt", {61'd0, cnt(3)}, 64'd0);

    // flush warp 0 while warp 2 holds data
    for (int i = 0; i < 3; i++) push(2'd0, 64'h40 + 64'(i));
    push(2'd2, 64'h50);
    push(2'd2, 64'h51);
    flush = 4'b0001; out_ready = 4'b0001;
    in_valid = 1'b1; in_wis = 2'd0; in_data = 64'h99;
    #1;
    check("fl_rdy", {63'd0, in_ready}, 64'd0);
    check("fl_pop", {60'd0, ibuf_pop}, 64'h0);
    tick();
    flush = '0; in_valid = 1'b0; out_ready = '0;
    check("fl_cnt0", {61'd0, cnt(0)}, 64'd0);
    check("fl_valid0", {63'd0, out_valid[0]}, 64'd0);
    check("fl_cnt2", {61'd0, cnt(2)}, 64'd2);
    check("fl_head2", head(2), 64'h50);
    push(2'd0, 64'h43);
    check("fl_after_head", head(0), 64'h43);
    check("fl_after_cnt", {61'd0, cnt(0)}, 64'd1);

    // every warp holds 2 entries, then async reset mid-cycle
    push(2'd0, 64'h44);
    push(2'd1, 64'h60); push(2'd1, 64'h61);
    push(2'd3, 64'h70); push(2'd3, 64'h71);
    check("pre_rst_cnt", {52'd0, count}, {52'd0, 12'b010_010_010_010});
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {60'd0, out_valid}, 64'h0);
    check("arst_count", {52'd0, count}, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", {60'd0, out_valid}, 64'h0);
    push(2'd1, 64'h77);
    check("post_rst_head", head(1), 64'h77);
    check("post_rst_cnt", {52'd0, count}, {52'd0, 12'b000_000_001_000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
